// File: rtl/switch_poll_if.sv
// Bus bundle for switch_poll_ctrl.
// Carries the PIO-side read master (m_*), the CPU-side register slave (s_*) and the irq line.
//   master : view used by switch_poll_ctrl (drives m_address, m_read, s_readdata, irq)
//   slave  : view used by the surrounding system (drives m_readdata and the s_* requests)
interface switch_poll_if;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;

    modport master (
        output m_address, m_read, s_readdata, irq,
        input  m_readdata, s_address, s_read, s_write, s_writedata
    );

    modport slave (
        input  m_address, m_read, s_readdata, irq,
        output m_readdata, s_address, s_read, s_write, s_writedata
    );
endinterface

// File: rtl/switch_poll_ctrl.sv
// Switch poll controller.
// Reads the switch PIO every POLL_DIV clocks, debounces the sampled bits over DEB_COUNT
// identical samples, captures rising/falling edges of the debounced value and raises a
// maskable level interrupt. CPU registers: 0 state (RO), 1 ctrl, 2 irq mask, 3 edge (W1C).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : switch_poll_if.master (PIO read master, CPU register slave, irq)
module switch_poll_ctrl #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned POLL_DIV  = 50000,
    parameter int unsigned DEB_COUNT = 10
) (
    input  logic          clk,
    input  logic          reset,
    switch_poll_if.master bus
);
    localparam int unsigned TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned CW = 8;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             m_read_q;
    logic [DW-1:0]    rdata_q, rdata_d;

    logic [WIDTH-1:0] sample, w1c, rise, fall;
    logic             en_c, tick, wr_ctrl, wr_mask, wr_edge;
    logic             unused_bits;

    // s_read has no effect (read data is refreshed every cycle); upper PIO bits are ignored
    assign unused_bits = ^{bus.s_read, bus.m_readdata, bus.s_writedata};

    assign bus.m_address  = 2'd0;
    assign bus.m_read     = m_read_q;
    assign bus.s_readdata = rdata_q;
    assign bus.irq        = |(edge_q & mask_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= S_IDLE;
            ctrl_q   <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            sw_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            m_read_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            fsm_q    <= fsm_d;
            ctrl_q   <= ctrl_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            sw_q     <= sw_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            m_read_q <= (fsm_d == S_READ);
            rdata_q  <= rdata_d;
        end
    end

    // Next-state: register writes, poll timer, poll FSM, debounce and edge capture
    always_comb begin
        fsm_d   = fsm_q;
        ctrl_d  = ctrl_q;
        mask_d  = mask_q;
        sw_d    = sw_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        rdata_d = '0;
        rise    = '0;
        fall    = '0;

        wr_ctrl = bus.s_write && (bus.s_address == 2'd1);
        wr_mask = bus.s_write && (bus.s_address == 2'd2);
        wr_edge = bus.s_write && (bus.s_address == 2'd3);
        w1c     = wr_edge ? bus.s_writedata[WIDTH-1:0] : '0;
        sample  = bus.m_readdata[WIDTH-1:0];

        if (wr_ctrl) ctrl_d = bus.s_writedata[2:0];
        if (wr_mask) mask_d = bus.s_writedata[WIDTH-1:0];

        // enable as it will be next cycle, so clearing it cancels a poll immediately
        en_c = ctrl_d[0];
        tick = ctrl_q[0] && (timer_q == TW'(POLL_DIV - 1));

        if (!ctrl_q[0] || !en_c || tick) timer_d = '0;
        else                             timer_d = timer_q + TW'(1);

        unique case (fsm_q)
            S_IDLE:    if (tick) fsm_d = S_READ;
            S_READ:    fsm_d = S_CAPTURE;
            S_CAPTURE: fsm_d = S_IDLE;
            default:   fsm_d = S_IDLE;
        endcase

        if (fsm_q == S_CAPTURE && en_c) begin
            if (sample == cand_q) begin
                if (cnt_q < CW'(DEB_COUNT)) cnt_d = cnt_q + CW'(1);
            end else begin
                cand_d = sample;
                cnt_d  = CW'(1);
            end
            if (cnt_d == CW'(DEB_COUNT)) sw_d = cand_d;
        end

        if (!en_c) begin
            fsm_d = S_IDLE;
            cnt_d = '0;
        end

        // sw_d equals sw_q unless the debounced value changes this cycle
        rise   = sw_d & ~sw_q & {WIDTH{ctrl_q[1]}};
        fall   = ~sw_d & sw_q & {WIDTH{ctrl_q[2]}};
        edge_d = (edge_q & ~w1c) | rise | fall;

        unique case (bus.s_address)
            2'd0:    rdata_d = DW'(sw_q);
            2'd1:    rdata_d = DW'(ctrl_q);
            2'd2:    rdata_d = DW'(mask_q);
            default: rdata_d = DW'(edge_q);
        endcase
    end
endmodule
